// File: rtl/clk_strobe_gen_m.sv
// ---------------------------------------------------------------------------
// clk_strobe_gen_m : multi-channel clock-enable strobe generator.
//
// Every channel divides the single system clock by a runtime-programmable
// divisor N. It emits a one-cycle strobe every N enabled cycles. It can also
// emit a 50%-duty divided clock (clk_out) that toggles on each strobe.
//
// Divisor writes go into a per-channel shadow register. The active divisor
// picks up the shadow value only at points where the count phase is
// restarted: terminal count, sync, enable low, or halted (N=0). Because of
// this, a period is never cut short and no runt pulse is produced.
//
// Build option:
//   CLK_STROBE_GEN_CLKOUT_EN  defined   -> clk_out toggle registers present
//                             undefined -> clk_out tied to 0
//
// Ports (top):
//   clk      in   system clock, the only clock
//   rst_n    in   asynchronous active-low reset
//   div_we   in   divisor write strobe
//   div_ch   in   channel index for the write (out-of-range ignored)
//   div_val  in   new divisor N
//   ch_en    in   per-channel run enable
//   sync     in   phase-align all channels to zero
//   strobe   out  per-channel one-cycle pulse every N enabled cycles
//   clk_out  out  per-channel divided clock, period 2N
// ---------------------------------------------------------------------------

// Per-channel divider. Registered outputs only.
module clk_strobe_ch_m #(
  parameter int CNT_W    = 16,
  parameter int DIV_INIT = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wval,
  output logic             o_strobe,
  output logic             o_clk_out
);

  logic [CNT_W-1:0] r_cnt, r_act, r_shd;
  logic             r_strobe;
  logic [CNT_W-1:0] w_shd_nxt, w_cnt_nxt, w_act_nxt;
  logic             w_run, w_term, w_reload;

  // A same-cycle write is visible to every reload point, including sync and
  // terminal count.
  assign w_shd_nxt = i_wr ? i_wval : r_shd;

  always_comb begin
    w_run    = i_en && !i_sync && (r_act != '0);
    // The check uses >= rather than ==. A count held while disabled can sit
    // above a divisor that was lowered meanwhile. That case must end the
    // period instead of wrapping through 2^CNT_W.
    w_term   = w_run && (r_cnt >= r_act - CNT_W'(1));
    w_reload = i_sync || !i_en || (r_act == '0) || w_term;

    w_cnt_nxt = r_cnt;
    if (i_sync || w_term) w_cnt_nxt = '0;
    else if (w_run)       w_cnt_nxt = r_cnt + CNT_W'(1);

    w_act_nxt = w_reload ? w_shd_nxt : r_act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_act    <= CNT_W'(DIV_INIT);
      r_shd    <= CNT_W'(DIV_INIT);
      r_strobe <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_act    <= w_act_nxt;
      r_shd    <= w_shd_nxt;
      r_strobe <= w_term;
    end
  end

  assign o_strobe = r_strobe;

`ifdef CLK_STROBE_GEN_CLKOUT_EN
  logic r_clk_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_clk_out <= 1'b0;
    else if (i_sync)  r_clk_out <= 1'b0;
    else if (w_term)  r_clk_out <= ~r_clk_out;
  end

  assign o_clk_out = r_clk_out;
`else
  assign o_clk_out = 1'b0;
`endif

endmodule

// Top: one divider instance per channel. Write decode is done here.
module clk_strobe_gen_m #(
  parameter  int NUM_CH   = 2,
  parameter  int CNT_W    = 16,
  parameter  int DIV_INIT = 12,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              div_we,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] strobe,
  output logic [NUM_CH-1:0] clk_out
);

  logic [NUM_CH-1:0] w_wr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // An index >= NUM_CH matches no channel, so that write is dropped.
    assign w_wr[g] = div_we && (div_ch == CH_W'(g));

    clk_strobe_ch_m #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (ch_en[g]),
      .i_sync    (sync),
      .i_wr      (w_wr[g]),
      .i_wval    (div_val),
      .o_strobe  (strobe[g]),
      .o_clk_out (clk_out[g])
    );
  end

endmodule

// File: tb/tb_clk_strobe_gen_m.sv
// Directed scoreboard bench for clk_strobe_gen_m (NUM_CH=2, DIV_INIT=12).
// The stimulus pushes the hand-computed strobe cycles (edge count since reset
// release) and the clk_out level each strobe should leave behind. A negedge
// monitor pops one entry per observed strobe and compares it.
module tb_clk_strobe_gen_m;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
`ifdef CLK_STROBE_GEN_CLKOUT_EN
  localparam bit CKEN = 1'b1;
`else
  localparam bit CKEN = 1'b0;
`endif

  typedef struct { int cyc; bit ck; } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              div_we;
  logic [0:0]        div_ch;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic [NUM_CH-1:0] strobe;
  logic [NUM_CH-1:0] clk_out;

  int   cyc;
  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  exp_t q [NUM_CH][$];
  bit   ck_exp [NUM_CH];

  clk_strobe_gen_m #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(12)) dut (
    .clk(clk), .rst_n(rst_n), .div_we(div_we), .div_ch(div_ch),
    .div_val(div_val), .ch_en(ch_en), .sync(sync),
    .strobe(strobe), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  // Rising-edge count since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Monitor: every strobe seen must match the head of that channel's queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (strobe[c]) begin
          vec_cnt++;
          if (q[c].size() == 0) begin
            miss_cnt++;
            $display("FAIL unexpected_strobe ch%0d: got strobe at cycle %0d, expected none", c, cyc);
          end else begin
            exp_t e;
            e = q[c].pop_front();
            if (cyc != e.cyc || clk_out[c] !== e.ck) begin
              miss_cnt++;
              $display("FAIL strobe ch%0d: got cycle %0d clk_out %0b, expected cycle %0d clk_out %0b",
                       c, cyc, clk_out[c], e.cyc, e.ck);
            end
          end
        end
      end
    end
  end

  task automatic exp_str(input int ch, input int t);
    exp_t e;
    ck_exp[ch] = ~ck_exp[ch];
    e.cyc = t;
    e.ck  = CKEN & ck_exp[ch];
    q[ch].push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    int k = 0;
    while (cyc != n && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (cyc != n) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL wait_cyc: got cycle %0d, expected %0d", cyc, n);
    end
  endtask

  task automatic chk(input string name, input logic [NUM_CH-1:0] got,
                     input logic [NUM_CH-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; div_we = 1'b0; div_ch = '0; div_val = '0;
    ch_en = 2'b11; sync = 1'b0;
    #1;
    chk("reset_strobe", strobe, 2'b00);
    chk("reset_clk_out", clk_out, 2'b00);

    // Channel 0: disabled for edges 6..12 with cnt=5, so the first strobe is
    // at 19 and the next at 31. A write of 0 (edge 21) halts it after 31. A
    // write of 4 (edge 35) restarts it with strobes at 39, 43, 47, 51.
    ck_exp[0] = 1'b0;
    foreach (ck_exp[c]) ck_exp[c] = 1'b0;
    exp_str(0, 19); exp_str(0, 31);
    exp_str(0, 39); exp_str(0, 43); exp_str(0, 47); exp_str(0, 51);
    // Channel 1: write 3 at edge 5; it finishes its 12-cycle period, then
    // strobes every 3.
    for (int t = 12; t <= 51; t += 3) exp_str(1, t);
    // Sync at edge 53 with a write of 5 to channel 1. clk_out restarts at 0.
    // Channel 0 (N=4) then strobes at 57, 61, 65; channel 1 (N=5) at 58, 63.
    ck_exp[0] = 1'b0; ck_exp[1] = 1'b0;
    exp_str(0, 57); exp_str(0, 61); exp_str(0, 65);
    exp_str(1, 58); exp_str(1, 63);

    @(negedge clk); rst_n = 1'b1;

    wait_cyc(4);  div_we = 1'b1; div_ch = 1'b1; div_val = 16'd3;
    wait_cyc(5);  div_we = 1'b0; ch_en[0] = 1'b0;
    wait_cyc(12); ch_en[0] = 1'b1;
    wait_cyc(20); div_we = 1'b1; div_ch = 1'b0; div_val = 16'd0;
    wait_cyc(21); div_we = 1'b0;
    wait_cyc(34); div_we = 1'b1; div_ch = 1'b0; div_val = 16'd4;
    wait_cyc(35); div_we = 1'b0;
    wait_cyc(52); sync = 1'b1; div_we = 1'b1; div_ch = 1'b1; div_val = 16'd5;
    wait_cyc(53); sync = 1'b0; div_we = 1'b0;

    // Async reset mid-period, away from any clock edge. At this point
    // strobe[0] is high and clk_out[0] may be high.
    wait_cyc(65);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_strobe", strobe, 2'b00);
    chk("async_rst_clk_out", clk_out, 2'b00);

    // Both divisors must be back at 12 after reset.
    ck_exp[0] = 1'b0; ck_exp[1] = 1'b0;
    exp_str(0, 12); exp_str(1, 12);
    @(negedge clk); rst_n = 1'b1;
    wait_cyc(14);

    for (int c = 0; c < NUM_CH; c++) begin
      vec_cnt++;
      if (q[c].size() != 0) begin
        miss_cnt++;
        $display("FAIL missing_strobe ch%0d: got %0d unconsumed entries, expected 0, next due cycle %0d",
                 c, q[c].size(), q[c][0].cyc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
